data_pack: RTL and testbench

- Upstream neighbour of the queue-output unpacker: assembles an incoming byte stream (sop/eop framed) into one DATAPACK_BIT-wide packet word and writes it into the WRR queue FIFO.
- Packet layout matches what the unpacker consumes: header byte 0 carries priority, header byte 1 carries address nibble, payload follows MSB-first, zero byte terminates.
- One packet buffered at a time; upstream back-pressured via i_ready while the write to the queue is pending.

---
 rtl/data_pack.sv | 178 +++++++++++++++++
 tb/tb_data_pack.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_pack.sv
// data_pack: assembles a sop/eop framed byte stream into one packet word
// (priority header, address header, MSB-first payload, zero terminated)
// and writes it into the WRR queue FIFO, one packet buffered at a time.
module data_pack #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DATAPACK_BIT = 1024,
  parameter int unsigned PRIORITY_BIT = 3,
  parameter int unsigned ADDR_BIT     = 16,
  parameter int unsigned MAX_BYTES    = 125
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic                    i_sop,
  input  logic                    i_eop,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [PRIORITY_BIT-1:0] i_prior,
  input  logic [ADDR_BIT-1:0]     i_addr,
  output logic                    i_ready,
  input  logic                    queue_full,
  output logic                    queue_wr,
  output logic [DATAPACK_BIT-1:0] Queue_in,
  output logic                    err_zero,
  output logic                    err_ovf,
  output logic                    err_sop,
  output logic [15:0]             pkt_cnt
);

  localparam int unsigned NUM_BYTES = DATAPACK_BIT / DATA_WIDTH;
  localparam int unsigned POS_W     = $clog2(NUM_BYTES);
  localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int unsigned PKT_W     = 16;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t                  state_q, state_d;
  logic [DATAPACK_BIT-1:0] buf_q, buf_d;
  logic [DATAPACK_BIT-1:0] qin_q, qin_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PKT_W-1:0]        pkt_q, pkt_d;
  logic                    ready_q, ready_d;
  logic                    wr_q, wr_d;
  logic                    ezero_q, ezero_d;
  logic                    eovf_q, eovf_d;
  logic                    esop_q, esop_d;

  logic                    accept;
  logic                    start;
  logic                    store;
  logic [DATA_WIDTH-1:0]   hdr0;
  logic [DATA_WIDTH-1:0]   hdr1;
  logic                    addr_unused;

  // Only the low address nibble travels in the header.
  assign addr_unused = ^i_addr[ADDR_BIT-1:4];

  assign accept = i_valid & ready_q;
  assign hdr0   = DATA_WIDTH'({1'b1, {(DATA_WIDTH-1-PRIORITY_BIT){1'b0}}, i_prior});
  assign hdr1   = DATA_WIDTH'({1'b1, {(DATA_WIDTH-5){1'b0}}, i_addr[3:0]});

  // Overwrite packet byte 'pos' (byte 0 sits in the MSBs).
  function automatic logic [DATAPACK_BIT-1:0] put_byte(
    input logic [DATAPACK_BIT-1:0] w,
    input logic [POS_W-1:0]        pos,
    input logic [DATA_WIDTH-1:0]   b
  );
    logic [DATAPACK_BIT-1:0] r;
    r = w;
    r[DATAPACK_BIT - 1 - 32'(pos) * DATA_WIDTH -: DATA_WIDTH] = b;
    return r;
  endfunction

  // Next-state, packet assembly and registered-output computation.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    qin_d   = qin_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    wr_d    = 1'b0;
    ezero_d = 1'b0;
    eovf_d  = 1'b0;
    esop_d  = 1'b0;
    start   = 1'b0;
    store   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && i_sop) start = 1'b1;
      end
      S_FILL: begin
        if (accept) begin
          if (i_sop) begin
            start  = 1'b1;
            esop_d = 1'b1;
          end else begin
            store = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (!queue_full) begin
          wr_d    = 1'b1;
          qin_d   = buf_q;
          pkt_d   = pkt_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Fresh packet: headers plus the sop byte as payload 0.
    if (start) begin
      buf_d = put_byte(put_byte('0, POS_W'(0), hdr0), POS_W'(1), hdr1);
      cnt_d = '0;
      if (i_data == '0) begin
        ezero_d = 1'b1;
      end else begin
        buf_d = put_byte(buf_d, POS_W'(2), i_data);
        cnt_d = CNT_W'(1);
      end
      state_d = S_FILL;
    end

    // Continuation byte: zeros and overflow bytes are dropped.
    if (store) begin
      if (i_data == '0) begin
        ezero_d = 1'b1;
      end else if (cnt_q == CNT_W'(MAX_BYTES)) begin
        eovf_d = 1'b1;
      end else begin
        buf_d = put_byte(buf_q, POS_W'(cnt_q) + POS_W'(2), i_data);
        cnt_d = cnt_q + 1'b1;
      end
    end

    if ((start || store) && i_eop) state_d = S_WRITE;

    // Ready stays low through the write cycle and the one after it.
    ready_d = (state_q != S_WRITE) && (state_d != S_WRITE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      qin_q   <= '0;
      cnt_q   <= '0;
      pkt_q   <= '0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      ezero_q <= 1'b0;
      eovf_q  <= 1'b0;
      esop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      qin_q   <= qin_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      ezero_q <= ezero_d;
      eovf_q  <= eovf_d;
      esop_q  <= esop_d;
    end
  end

  assign i_ready  = ready_q;
  assign queue_wr = wr_q;
  assign Queue_in = qin_q;
  assign err_zero = ezero_q;
  assign err_ovf  = eovf_q;
  assign err_sop  = esop_q;
  assign pkt_cnt  = pkt_q;

endmodule

// File: tb/tb_data_pack.sv
// tb_data_pack: table-driven cycle checks, directed corner sequences and
// randomized packets scored against a queue-based packet model.
module tb_data_pack;

  localparam int unsigned PW   = 1024;
  localparam int unsigned NB   = 128;
  localparam int unsigned MAXB = 125;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_valid = 1'b0, i_sop = 1'b0, i_eop = 1'b0;
  logic [7:0]    i_data = '0;
  logic [2:0]    i_prior = '0;
  logic [15:0]   i_addr = '0;
  logic          queue_full = 1'b0;
  logic          i_ready, queue_wr, err_zero, err_ovf, err_sop;
  logic [PW-1:0] Queue_in;
  logic [15:0]   pkt_cnt;

  always #5 clk = ~clk;

  data_pack dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
    .i_data(i_data), .i_prior(i_prior), .i_addr(i_addr), .i_ready(i_ready),
    .queue_full(queue_full), .queue_wr(queue_wr), .Queue_in(Queue_in),
    .err_zero(err_zero), .err_ovf(err_ovf), .err_sop(err_sop), .pkt_cnt(pkt_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    logic [7:0] ab, eb;
    int idx;
    checks++;
    if (act !== exp) begin
      errors++;
      idx = 0; ab = '0; eb = '0;
      for (int k = NB - 1; k >= 0; k--) begin
        if (act[PW-1-k*8 -: 8] !== exp[PW-1-k*8 -: 8]) begin
          idx = k; ab = act[PW-1-k*8 -: 8]; eb = exp[PW-1-k*8 -: 8];
        end
      end
      $display("FAIL %s first bad byte %0d actual=%02h expected=%02h", name, idx, ab, eb);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  logic          m_active = 1'b0;
  logic [2:0]    m_p;
  logic [3:0]    m_a;
  byte unsigned  m_pay[$];
  logic [PW-1:0] exp_q[$];
  int            m_ez = 0, m_eo = 0, m_es = 0;

  function automatic logic [PW-1:0] pack(input logic [2:0] p, input logic [3:0] a,
                                         input byte unsigned pay[$]);
    logic [PW-1:0] w;
    w = '0;
    w[PW-1 -: 8] = {1'b1, 4'b0000, p};
    w[PW-9 -: 8] = {1'b1, 3'b000, a};
    foreach (pay[k]) w[PW-1-(2+k)*8 -: 8] = pay[k];
    return w;
  endfunction

  task automatic take(input logic [7:0] d);
    if (d == 8'h00) m_ez++;
    else if (m_pay.size() >= MAXB) m_eo++;
    else m_pay.push_back(d);
  endtask

  task automatic model_byte(input logic s, input logic e, input logic [7:0] d,
                            input logic [2:0] p, input logic [15:0] a);
    if (s) begin
      if (m_active) m_es++;
      m_active = 1'b1; m_p = p; m_a = a[3:0]; m_pay.delete();
      take(d);
    end else if (m_active) begin
      take(d);
    end
    if (m_active && e) begin
      exp_q.push_back(pack(m_p, m_a, m_pay));
      m_active = 1'b0;
    end
  endtask

  // ---------------- output monitor / scoreboard ----------------
  logic          mon_en = 1'b0;
  logic [PW-1:0] last_word = '0;
  int            n_ez = 0, n_eo = 0, n_es = 0, n_wr = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      n_ez += int'(err_zero);
      n_eo += int'(err_ovf);
      n_es += int'(err_sop);
      if (queue_wr) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write pkt_cnt=%0d", pkt_cnt);
        end else begin
          last_word = exp_q.pop_front();
          chk_word("queue_in", Queue_in, last_word);
        end
        n_wr++;
        chk("pkt_cnt_on_write", 32'(pkt_cnt), 32'(n_wr));
      end else begin
        chk_word("queue_in_hold", Queue_in, last_word);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic rnd_full = 1'b0;

  task automatic cyc();
    @(posedge clk); #1;
    if (rnd_full) queue_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic do_reset(input int n);
    mon_en = 1'b0; rnd_full = 1'b0;
    rst_n = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; queue_full = 1'b0;
    repeat (n) cyc();
    chk("rst_ready", 32'(i_ready), 32'd0);
    chk("rst_queue_wr", 32'(queue_wr), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_errs", 32'({err_zero, err_ovf, err_sop}), 32'd0);
    chk_word("rst_queue_in", Queue_in, '0);
    rst_n = 1'b0;
    m_active = 1'b0; m_pay.delete(); exp_q.delete(); last_word = '0; n_wr = 0;
    cyc();
    chk("ready_after_rst", 32'(i_ready), 32'd1);
    mon_en = 1'b1;
  endtask

  task automatic send(input logic s, input logic e, input logic [7:0] d,
                      input logic [2:0] p, input logic [15:0] a);
    int n;
    n = 0;
    while (!i_ready && n < 64) begin cyc(); n++; end
    if (!i_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout ready=%0d expected=1", i_ready);
      return;
    end
    i_valid = 1'b1; i_sop = s; i_eop = e; i_data = d; i_prior = p; i_addr = a;
    model_byte(s, e, d, p, a);
    cyc();
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    rnd_full = 1'b0; queue_full = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin cyc(); n++; end
    cyc(); cyc();
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_ezero_cnt"}, 32'(n_ez), 32'(m_ez));
    chk({name, "_eovf_cnt"}, 32'(n_eo), 32'(m_eo));
    chk({name, "_esop_cnt"}, 32'(n_es), 32'(m_es));
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic v, s, e; logic [7:0] d; logic [2:0] p; logic [15:0] a; logic f;
    logic rdy, wr, ez, es; logic [15:0] pc;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl[NV];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic prev_rdy;
    int   eo0, len;
    logic [7:0] d;
    logic [2:0] p;
    logic [15:0] a;
    logic [7:0] bt;

    //          v     s     e     d      p     a        f       rdy   wr    ez    es    pc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'hA1, 3'd5, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'hB2, 3'd5, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'hC3, 3'd5, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'hA1, 3'd5, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'hB2, 3'd5, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'hC3, 3'd5, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h55, 3'd1, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h55, 3'd1, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h55, 3'd1, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h11, 3'd2, 16'h00A1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 16'h00A1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h22, 3'd2, 16'h00A1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 8'h33, 3'd6, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 8'h44, 3'd6, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 8'h99, 3'd3, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[21] = '{1'b1, 1'b1, 1'b1, 8'h00, 3'd7, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4};

    do_reset(2);

    // Cycle-exact table: latency, back-pressure, zero drop, sop restart.
    prev_rdy = 1'b1;
    for (int i = 0; i < NV; i++) begin
      i_valid = tbl[i].v; i_sop = tbl[i].s; i_eop = tbl[i].e; i_data = tbl[i].d;
      i_prior = tbl[i].p; i_addr = tbl[i].a; queue_full = tbl[i].f;
      if (tbl[i].v && prev_rdy) model_byte(tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].p, tbl[i].a);
      cyc();
      chk($sformatf("v%0d_ready", i), 32'(i_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_queue_wr", i), 32'(queue_wr), 32'(tbl[i].wr));
      chk($sformatf("v%0d_err_zero", i), 32'(err_zero), 32'(tbl[i].ez));
      chk($sformatf("v%0d_err_sop", i), 32'(err_sop), 32'(tbl[i].es));
      chk($sformatf("v%0d_err_ovf", i), 32'(err_ovf), 32'd0);
      chk($sformatf("v%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(tbl[i].pc));
      prev_rdy = tbl[i].rdy;
      if (i == 4 || i == 12) chk_word($sformatf("v%0d_pkt_a_word", i), Queue_in, {40'h8583A1B2C3, 984'b0});
    end
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    drain("table");

    // Overflow: 130 nonzero bytes, 125 kept, 5 drop pulses.
    eo0 = n_eo;
    send(1'b1, 1'b0, 8'h01, 3'd1, 16'h00F2);
    for (int b = 2; b <= 130; b++) send(1'b0, b == 130, 8'(b), 3'd1, 16'h00F2);
    drain("ovf");
    chk("ovf_pulses", 32'(n_eo - eo0), 32'd5);
    bt = Queue_in[PW-1-126*8 -: 8];
    chk("ovf_byte126", 32'(bt), 32'h7D);
    bt = Queue_in[7:0];
    chk("ovf_byte127", 32'(bt), 32'h00);

    // Reset while filling: no write, counters cleared, next packet clean.
    send(1'b1, 1'b0, 8'h5A, 3'd4, 16'h0002);
    for (int b = 1; b < 10; b++) send(1'b0, 1'b0, 8'(8'h10 + b), 3'd4, 16'h0002);
    do_reset(1);
    repeat (3) cyc();
    chk("mid_fill_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("mid_fill_no_wr", 32'(n_wr), 32'd0);
    send(1'b1, 1'b0, 8'hDE, 3'd3, 16'h000C);
    send(1'b0, 1'b1, 8'hAD, 3'd3, 16'h000C);
    drain("after_fill_rst");
    chk("after_fill_rst_pkt", 32'(pkt_cnt), 32'd1);

    // Reset while a write is held off by a full queue.
    queue_full = 1'b1;
    send(1'b1, 1'b1, 8'h77, 3'd2, 16'h0001);
    repeat (3) cyc();
    chk("held_wr_low", 32'(queue_wr), 32'd0);
    do_reset(1);
    repeat (3) cyc();
    chk("mid_write_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("mid_write_no_wr", 32'(n_wr), 32'd0);

    // Randomized packets with gaps, zeros, restarts and back-pressure.
    rnd_full = 1'b1;
    for (int n = 0; n < 40; n++) begin
      p = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 132)) : int'($urandom_range(0, 12));
      if ($urandom_range(0, 5) == 0) send(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), p, a);
      for (int b = 0; b <= len; b++) begin
        d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        if ($urandom_range(0, 3) == 0) cyc();
        send(b == 0, (b == len) && ($urandom_range(0, 9) != 0), d, p, a);
      end
    end
    send(1'b1, 1'b1, 8'h42, 3'd0, 16'h0000);
    drain("random");
    chk("random_pkt_cnt", 32'(pkt_cnt), 32'(n_wr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
